// File: rtl/jt5205_sample_ctrl.sv
// ADPCM sample playback sequencer: fetches packed 4-bit codes from ROM and feeds one per cen_lo.
// Latency: first nibble on the first cen_lo after the first byte lands; ROM request held until rom_ok.
// Backpressure: one byte of lookahead; a nibble due with nothing buffered sets sticky underrun and din holds.
module jt5205_sample_ctrl #(
  parameter int AW       = 17,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          cen_lo,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [7:0]    rom_data,
  output logic [3:0]    din,
  output logic          adpcm_rst,
  output logic          busy,
  output logic          irq,
  output logic          underrun
);

  typedef enum logic [2:0] {IDLE, PRIME, PLAY, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  // One extra bit so fetching past the top address compares as "beyond end" instead of wrapping
  logic [AW:0]   fetch_q, fetch_d;
  logic [AW-1:0] end_q, end_d;
  logic [7:0]    cur_q, cur_d, nxt_q, nxt_d;
  logic          cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic          nib_sel_q, nib_sel_d;
  logic [3:0]    din_q, din_d;
  logic          arst_q, arst_d;
  logic          under_q, under_d;

  logic          fetching, accept, last_byte;
  logic [3:0]    first_nib, second_nib;

  assign fetching   = (state_q == PRIME) || (state_q == PLAY);
  assign rom_cs     = fetching && !nxt_v_q && (fetch_q <= {1'b0, end_q});
  assign accept     = rom_cs && rom_ok;
  assign last_byte  = (fetch_q > {1'b0, end_q}) && !nxt_v_q;
  assign first_nib  = HI_FIRST ? cur_q[7:4] : cur_q[3:0];
  assign second_nib = HI_FIRST ? cur_q[3:0] : cur_q[7:4];

  assign rom_addr  = fetch_q[AW-1:0];
  assign din       = din_q;
  assign adpcm_rst = arst_q;
  assign busy      = (state_q == PRIME) || (state_q == PLAY) || (state_q == DRAIN);
  assign irq       = (state_q == DONE);
  assign underrun  = under_q;

  // Next-state: ROM accept, buffer refill, nibble sequencing, then start/stop overrides
  always_comb begin
    state_d   = state_q;
    fetch_d   = fetch_q;
    end_d     = end_q;
    cur_d     = cur_q;
    cur_v_d   = cur_v_q;
    nxt_d     = nxt_q;
    nxt_v_d   = nxt_v_q;
    nib_sel_d = nib_sel_q;
    din_d     = din_q;
    arst_d    = arst_q;
    under_d   = under_q;

    if (accept) begin
      nxt_d   = rom_data;
      nxt_v_d = 1'b1;
      fetch_d = fetch_q + 1'b1;
    end
    if (!cur_v_q && nxt_v_q) begin
      cur_d   = nxt_q;
      cur_v_d = 1'b1;
      nxt_v_d = accept;
    end

    case (state_q)
      PRIME: begin
        if (cen_lo && cur_v_q) begin
          din_d     = first_nib;
          arst_d    = 1'b0;
          nib_sel_d = 1'b1;
          state_d   = PLAY;
        end
      end
      PLAY: begin
        if (cen_lo) begin
          if (nib_sel_q) begin
            din_d     = second_nib;
            cur_v_d   = 1'b0;
            nib_sel_d = 1'b0;
            if (last_byte) state_d = DRAIN;
          end else if (cur_v_q) begin
            din_d     = first_nib;
            nib_sel_d = 1'b1;
          end else begin
            under_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Decoder still has to consume the last code at this strobe
        if (cen_lo) begin
          arst_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: arst_d  = 1'b1;
    endcase

    if (stop) begin
      state_d   = IDLE;
      arst_d    = 1'b1;
      cur_v_d   = 1'b0;
      nxt_v_d   = 1'b0;
      nib_sel_d = 1'b0;
    end else if (start) begin
      end_d     = end_addr;
      fetch_d   = {1'b0, start_addr};
      under_d   = 1'b0;
      nib_sel_d = 1'b0;
      cur_v_d   = 1'b0;
      nxt_v_d   = 1'b0;
      arst_d    = 1'b1;
      state_d   = (start_addr > end_addr) ? DONE : PRIME;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fetch_q   <= '0;
      end_q     <= '0;
      cur_q     <= '0;
      cur_v_q   <= 1'b0;
      nxt_q     <= '0;
      nxt_v_q   <= 1'b0;
      nib_sel_q <= 1'b0;
      din_q     <= '0;
      arst_q    <= 1'b1;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      end_q     <= end_d;
      cur_q     <= cur_d;
      cur_v_q   <= cur_v_d;
      nxt_q     <= nxt_d;
      nxt_v_q   <= nxt_v_d;
      nib_sel_q <= nib_sel_d;
      din_q     <= din_d;
      arst_q    <= arst_d;
      under_q   <= under_d;
    end
  end

endmodule

// File: tb/tb_jt5205_sample_ctrl.sv
// Directed bench for jt5205_sample_ctrl: two instances (HI_FIRST=1 and 0) share one ROM responder.
// Each step drives inputs #1 after the clock edge and samples outputs one cycle later at the same point.
// Playback is recorded as {adpcm_rst,din} at every strobe where the decoder is (or just was) out of reset.
module tb_jt5205_sample_ctrl;

  logic        clk = 1'b0;
  logic        rst, cen_lo, start, stop, rom_ok;
  logic [16:0] start_addr, end_addr;
  logic [7:0]  rom_data;

  logic [16:0] rom_addr, rom_addr_b;
  logic        rom_cs, rom_cs_b;
  logic [3:0]  din_a, din_b;
  logic        adpcm_rst_a, adpcm_rst_b, busy_a, busy_b, irq_a, irq_b, underrun_a, underrun_b;

  int checks = 0;
  int errors = 0;
  int ph = 0, wait_n = 0, irq_cnt = 0, irq_cnt_b = 0, accepts = 0, cs_seen = 0;
  logic        rom_auto = 1'b1, man_ok = 1'b0, slow_en = 1'b0;
  logic [16:0] slow_addr = 17'h0;
  logic [4:0]  log_a[$], log_b[$], exp_q[$];

  always #5 clk = ~clk;

  jt5205_sample_ctrl #(.AW(17), .HI_FIRST(1'b1)) dut_a (
    .rst(rst), .clk(clk), .cen_lo(cen_lo), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_ok(rom_ok), .rom_data(rom_data), .din(din_a), .adpcm_rst(adpcm_rst_a),
    .busy(busy_a), .irq(irq_a), .underrun(underrun_a));

  jt5205_sample_ctrl #(.AW(17), .HI_FIRST(1'b0)) dut_b (
    .rst(rst), .clk(clk), .cen_lo(cen_lo), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr_b), .rom_cs(rom_cs_b),
    .rom_ok(rom_ok), .rom_data(rom_data), .din(din_b), .adpcm_rst(adpcm_rst_b),
    .busy(busy_b), .irq(irq_b), .underrun(underrun_b));

  function automatic logic [7:0] rom_byte(input logic [16:0] a);
    case (a)
      17'h00010: return 8'hA5;
      17'h00011: return 8'h3C;
      17'h00012: return 8'h71;
      17'h00013: return 8'h9E;
      17'h1FFFF: return 8'h4B;
      default:   return 8'hEE;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input bit use_b);
    int n;
    n = use_b ? log_b.size() : log_a.size();
    check({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check($sformatf("%s_%0d", tag, i), 32'(use_b ? log_b[i] : log_a[i]), 32'(exp_q[i]));
  endtask

  // One clock: drive strobe and ROM response, clock, then record what happened
  task automatic tick();
    logic pr_a, pr_b;
    cen_lo = ((ph % 16) == 15);
    if (rom_auto) begin
      if (rom_cs) begin
        rom_ok = (wait_n >= ((slow_en && rom_addr == slow_addr) ? 40 : 2));
        wait_n++;
      end else begin
        rom_ok = 1'b0;
        wait_n = 0;
      end
      rom_data = rom_byte(rom_addr);
    end else begin
      rom_ok   = man_ok;
      rom_data = 8'hEE;
    end
    if (rom_cs && rom_ok) accepts++;
    pr_a = adpcm_rst_a;
    pr_b = adpcm_rst_b;
    @(posedge clk);
    #1;
    ph++;
    start = 1'b0;
    stop  = 1'b0;
    if (irq_a) irq_cnt++;
    if (irq_b) irq_cnt_b++;
    if (rom_cs) cs_seen++;
    if (cen_lo) begin
      if (!pr_a || !adpcm_rst_a) log_a.push_back({adpcm_rst_a, din_a});
      if (!pr_b || !adpcm_rst_b) log_b.push_back({adpcm_rst_b, din_b});
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input logic [16:0] s, input logic [16:0] e);
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    ph         = 8;
    log_a.delete();
    log_b.delete();
    irq_cnt = 0; irq_cnt_b = 0; accepts = 0; cs_seen = 0;
    tick();
  endtask

  initial begin
    int  n;
    bit  armed;
    rst = 1'b1; cen_lo = 1'b0; start = 1'b0; stop = 1'b0; rom_ok = 1'b0;
    rom_data = 8'h00; start_addr = '0; end_addr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_din", 32'(din_a), 32'h0);
    check("rst_adpcm_rst", 32'(adpcm_rst_a), 32'h1);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_irq", 32'(irq_a), 32'h0);
    check("rst_underrun", 32'(underrun_a), 32'h0);
    check("rst_rom_cs", 32'(rom_cs), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    rst = 1'b0;
    run(4);

    // Basic playback, both nibble orders
    do_start(17'h10, 17'h11);
    check("basic_busy", 32'(busy_a), 32'h1);
    check("basic_prime_rst", 32'(adpcm_rst_a), 32'h1);
    check("basic_cs", 32'(rom_cs), 32'h1);
    check("basic_addr", 32'(rom_addr), 32'h10);
    run(100);
    exp_q = '{5'h0A, 5'h05, 5'h03, 5'h0C, 5'h1C};
    check_log("basic_hi", 1'b0);
    exp_q = '{5'h05, 5'h0A, 5'h0C, 5'h03, 5'h13};
    check_log("basic_lo", 1'b1);
    check("basic_irq", 32'(irq_cnt), 32'd1);
    check("basic_irq_b", 32'(irq_cnt_b), 32'd1);
    check("basic_accepts", 32'(accepts), 32'd2);
    check("basic_busy_end", 32'(busy_a), 32'h0);
    check("basic_underrun", 32'(underrun_a), 32'h0);

    // Slow ROM on the second byte
    slow_en = 1'b1; slow_addr = 17'h11;
    do_start(17'h10, 17'h11);
    run(110);
    slow_en = 1'b0;
    exp_q = '{5'h0A, 5'h05, 5'h05, 5'h03, 5'h0C, 5'h1C};
    check_log("slow", 1'b0);
    check("slow_underrun", 32'(underrun_a), 32'h1);
    check("slow_underrun_b", 32'(underrun_b), 32'h1);
    check("slow_irq", 32'(irq_cnt), 32'd1);

    // Stop while a request is outstanding; a late rom_ok must be ignored
    do_start(17'h10, 17'h13);
    check("stop_underrun_clr", 32'(underrun_a), 32'h0);
    armed = 1'b0;
    n = 0;
    while (!armed && n < 200) begin
      tick();
      n++;
      if (log_a.size() >= 2 && rom_cs) armed = 1'b1;
    end
    check("stop_armed", 32'(armed), 32'h1);
    check("stop_playing", 32'(adpcm_rst_a), 32'h0);
    rom_auto = 1'b0; man_ok = 1'b0;
    stop = 1'b1;
    tick();
    check("stop_adpcm_rst", 32'(adpcm_rst_a), 32'h1);
    check("stop_busy", 32'(busy_a), 32'h0);
    check("stop_rom_cs", 32'(rom_cs), 32'h0);
    run(2);
    man_ok = 1'b1;
    tick();
    man_ok = 1'b0;
    run(40);
    check("stop_no_irq", 32'(irq_cnt), 32'd0);
    check("stop_idle", 32'(busy_a), 32'h0);
    check("stop_cs_after", 32'(rom_cs), 32'h0);
    check("stop_no_play", 32'(log_a.size()), 32'd2);
    rom_auto = 1'b1; wait_n = 0;

    // Zero-length sample
    do_start(17'h20, 17'h1F);
    check("zero_irq", 32'(irq_a), 32'h1);
    check("zero_busy", 32'(busy_a), 32'h0);
    tick();
    check("zero_irq_once", 32'(irq_a), 32'h0);
    run(20);
    check("zero_irq_cnt", 32'(irq_cnt), 32'd1);
    check("zero_no_req", 32'(cs_seen), 32'd0);

    // Start and stop together: stop wins
    start_addr = 17'h10; end_addr = 17'h11;
    start = 1'b1; stop = 1'b1;
    tick();
    check("ss_busy", 32'(busy_a), 32'h0);
    check("ss_adpcm_rst", 32'(adpcm_rst_a), 32'h1);
    run(20);
    check("ss_no_req", 32'(cs_seen), 32'd0);
    check("ss_irq_cnt", 32'(irq_cnt), 32'd1);

    // Top-of-ROM single byte: fetch must not wrap
    do_start(17'h1FFFF, 17'h1FFFF);
    run(60);
    exp_q = '{5'h04, 5'h0B, 5'h1B};
    check_log("top", 1'b0);
    check("top_accepts", 32'(accepts), 32'd1);
    check("top_irq", 32'(irq_cnt), 32'd1);

    // Asynchronous reset during playback
    do_start(17'h10, 17'h11);
    run(30);
    check("arst_playing", 32'(adpcm_rst_a), 32'h0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_adpcm_rst", 32'(adpcm_rst_a), 32'h1);
    check("arst_busy", 32'(busy_a), 32'h0);
    check("arst_din", 32'(din_a), 32'h0);
    check("arst_rom_cs", 32'(rom_cs), 32'h0);
    check("arst_rom_cs_b", 32'(rom_cs_b), 32'h0);
    check("arst_rom_addr_b", 32'(rom_addr_b), 32'h0);
    check("arst_busy_b", 32'(busy_b), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
